// File: rtl/multicycle_control_if.sv
// Bundle of instruction-register, ALU-flag, memory-handshake and datapath-control signals
// exchanged between the multicycle control FSM and the rest of the datapath.
interface multicycle_control_if #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               IorD;
    logic               IRWrite;
    logic               PCWrite;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrc;
    logic               Branch;
    logic               BNE;
    logic               ZorS;
    logic               JALCtrl;
    logic               MemWrite;
    logic               MemRead;
    logic               MemToReg;
    logic               BW;
    logic               JumpReg;
    logic [ALUOP_W-1:0] ALUOp;
    logic [2:0]         state;
    logic               trap;
    logic [1:0]         trap_cause;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, IorD, IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, Branch, BNE, ZorS,
               JALCtrl, MemWrite, MemRead, MemToReg, BW, JumpReg, ALUOp, state, trap,
               trap_cause, instr_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, IorD, IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, Branch, BNE, ZorS,
               JALCtrl, MemWrite, MemRead, MemToReg, BW, JumpReg, ALUOp, state, trap,
               trap_cause, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with a req/ready memory port,
// sticky traps for illegal opcodes and memory timeouts, and a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [5:0] OpR = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04;
    localparam logic [5:0] OpBne = 6'h05, OpAddi = 6'h08, OpSlti = 6'h0A, OpAndi = 6'h0C;
    localparam logic [5:0] OpOri = 6'h0D, OpLui = 6'h0F, OpLw = 6'h23, OpLbu = 6'h24;
    localparam logic [5:0] OpSb = 6'h28, OpSw = 6'h2B;
    localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnJr = 6'h08, FnAdd = 6'h20;
    localparam logic [5:0] FnAnd = 6'h24, FnOr = 6'h25, FnNor = 6'h27, FnSlt = 6'h2A;

    localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(0), AluOr = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(2), AluNor = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] AluSll = ALUOP_W'(4), AluSrl = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(6), AluSlt = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] AluLui = ALUOP_W'(8);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

    state_e           state_q;
    logic [5:0]       op_q, funct_q;
    logic [WaitW-1:0] wait_q;
    logic [CNT_W-1:0] count_q;
    logic             trap_q;
    logic [1:0]       cause_q;

    function automatic logic legal_instr(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OpR: begin
                case (fn)
                    FnSll, FnSrl, FnJr, FnAdd, FnAnd, FnOr, FnNor, FnSlt: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OpJ, OpJal, OpBeq, OpBne, OpAddi, OpSlti, OpAndi, OpOri, OpLui, OpLw, OpLbu,
            OpSb, OpSw: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [ALUOP_W-1:0] r_alu_op(input logic [5:0] fn);
        case (fn)
            FnAnd:   return AluAnd;
            FnOr:    return AluOr;
            FnNor:   return AluNor;
            FnSll:   return AluSll;
            FnSrl:   return AluSrl;
            FnSlt:   return AluSlt;
            default: return AluAdd;
        endcase
    endfunction

    function automatic logic [ALUOP_W-1:0] i_alu_op(input logic [5:0] op);
        case (op)
            OpAndi:  return AluAnd;
            OpOri:   return AluOr;
            OpSlti:  return AluSlt;
            OpLui:   return AluLui;
            default: return AluAdd;
        endcase
    endfunction

    logic is_rtype, is_jr, is_branch, is_jump, is_load, is_store, is_word, timeout;

    assign is_rtype  = (op_q == OpR);
    assign is_jr     = is_rtype && (funct_q == FnJr);
    assign is_branch = (op_q == OpBeq) || (op_q == OpBne);
    assign is_jump   = (op_q == OpJ) || (op_q == OpJal) || is_jr;
    assign is_load   = (op_q == OpLw) || (op_q == OpLbu);
    assign is_store  = (op_q == OpSw) || (op_q == OpSb);
    assign is_word   = (op_q == OpLw) || (op_q == OpSw);
    // A ready arriving on the cycle the wait count hits the limit still completes the access.
    assign timeout   = (MEM_TIMEOUT != 0) && (wait_q == WaitMax) && !bus.mem_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
            op_q    <= '0;
            funct_q <= '0;
            wait_q  <= '0;
            count_q <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            case (state_q)
                StFetch, StMem: begin
                    if (bus.mem_ready) begin
                        wait_q <= '0;
                        if (state_q == StFetch) begin
                            state_q <= StDecode;
                        end else if (is_store) begin
                            state_q <= StFetch;
                            count_q <= count_q + CNT_W'(1);
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (timeout) begin
                        state_q <= StTrap;
                        trap_q  <= 1'b1;
                        cause_q <= 2'b10;
                    end else if (wait_q != '1) begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StDecode: begin
                    op_q    <= bus.opcode;
                    funct_q <= bus.funct;
                    wait_q  <= '0;
                    if (legal_instr(bus.opcode, bus.funct)) begin
                        state_q <= StExec;
                    end else begin
                        state_q <= StTrap;
                        trap_q  <= 1'b1;
                        cause_q <= 2'b01;
                    end
                end
                StExec: begin
                    wait_q <= '0;
                    if (is_branch || is_jump) begin
                        state_q <= StFetch;
                        count_q <= count_q + CNT_W'(1);
                    end else if (is_load || is_store) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StWb: begin
                    wait_q  <= '0;
                    state_q <= StFetch;
                    count_q <= count_q + CNT_W'(1);
                end
                StTrap:  state_q <= StTrap;
                default: state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        bus.mem_req  = 1'b0;
        bus.IorD     = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.Branch   = 1'b0;
        bus.BNE      = 1'b0;
        bus.ZorS     = 1'b0;
        bus.JALCtrl  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemToReg = 1'b0;
        bus.BW       = 1'b0;
        bus.JumpReg  = 1'b0;
        bus.ALUOp    = '0;
        if (rst) begin
            case (state_q)
                StFetch: begin
                    bus.mem_req = 1'b1;
                    bus.MemRead = 1'b1;
                    bus.ALUSrc  = 1'b1;
                    bus.ALUOp   = AluAdd;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                StExec: begin
                    if (is_branch) begin
                        bus.ALUOp   = AluSub;
                        bus.ZorS    = 1'b1;
                        bus.Branch  = 1'b1;
                        bus.BNE     = (op_q == OpBne);
                        bus.PCWrite = (op_q == OpBne) ? !bus.zero : bus.zero;
                    end else if (is_jr) begin
                        bus.JumpReg = 1'b1;
                        bus.PCWrite = 1'b1;
                    end else if (is_jump) begin
                        bus.JALCtrl  = 1'b1;
                        bus.PCWrite  = 1'b1;
                        bus.RegWrite = (op_q == OpJal);
                    end else if (is_load || is_store) begin
                        bus.ALUSrc = 1'b1;
                        bus.ZorS   = 1'b1;
                        bus.ALUOp  = AluAdd;
                        bus.BW     = is_word;
                    end else if (is_rtype) begin
                        bus.RegDst = 1'b1;
                        bus.ALUOp  = r_alu_op(funct_q);
                    end else begin
                        bus.ALUSrc = 1'b1;
                        bus.ZorS   = (op_q == OpAddi) || (op_q == OpAndi) || (op_q == OpSlti);
                        bus.ALUOp  = i_alu_op(op_q);
                    end
                end
                StMem: begin
                    bus.mem_req  = 1'b1;
                    bus.IorD     = 1'b1;
                    bus.MemRead  = is_load;
                    bus.MemWrite = is_store;
                    bus.BW       = is_word;
                end
                StWb: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = is_rtype;
                    bus.MemToReg = is_load;
                    bus.BW       = is_word;
                end
                default: ;
            endcase
        end
    end

    assign bus.state       = rst ? state_q : 3'd0;
    assign bus.trap        = rst & trap_q;
    assign bus.trap_cause  = rst ? cause_q : 2'b00;
    assign bus.instr_count = rst ? count_q : '0;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized instruction
// streams checked against a phase-list reference model of the instruction set.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_W(4), .CNT_W(4)) bus ();

    multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int assertions = 0;
    int failures   = 0;

    logic any_out;
    assign any_out = |{bus.mem_req, bus.IorD, bus.IRWrite, bus.PCWrite, bus.RegDst, bus.RegWrite,
                       bus.ALUSrc, bus.Branch, bus.BNE, bus.ZorS, bus.JALCtrl, bus.MemWrite,
                       bus.MemRead, bus.MemToReg, bus.BW, bus.JumpReg, bus.ALUOp, bus.state,
                       bus.trap, bus.trap_cause, bus.instr_count};

    localparam int KAlu = 0, KLoad = 1, KStore = 2, KBr = 3, KJump = 4;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [3:0] alu;
        logic       zors;
        logic       bw;
    } ins_t;

    function automatic ins_t ins_info(input int idx);
        ins_t r;
        case (idx)
            0:  r = '{6'h00, 6'h20, KAlu,   4'd2, 1'b0, 1'b0};
            1:  r = '{6'h00, 6'h24, KAlu,   4'd0, 1'b0, 1'b0};
            2:  r = '{6'h00, 6'h27, KAlu,   4'd3, 1'b0, 1'b0};
            3:  r = '{6'h00, 6'h25, KAlu,   4'd1, 1'b0, 1'b0};
            4:  r = '{6'h00, 6'h2A, KAlu,   4'd7, 1'b0, 1'b0};
            5:  r = '{6'h00, 6'h00, KAlu,   4'd4, 1'b0, 1'b0};
            6:  r = '{6'h00, 6'h02, KAlu,   4'd5, 1'b0, 1'b0};
            7:  r = '{6'h00, 6'h08, KJump,  4'd0, 1'b0, 1'b0};
            8:  r = '{6'h08, 6'h11, KAlu,   4'd2, 1'b1, 1'b0};
            9:  r = '{6'h0C, 6'h3F, KAlu,   4'd0, 1'b1, 1'b0};
            10: r = '{6'h0D, 6'h00, KAlu,   4'd1, 1'b0, 1'b0};
            11: r = '{6'h0A, 6'h05, KAlu,   4'd7, 1'b1, 1'b0};
            12: r = '{6'h0F, 6'h21, KAlu,   4'd8, 1'b0, 1'b0};
            13: r = '{6'h04, 6'h00, KBr,    4'd6, 1'b1, 1'b0};
            14: r = '{6'h05, 6'h13, KBr,    4'd6, 1'b1, 1'b0};
            15: r = '{6'h02, 6'h00, KJump,  4'd0, 1'b0, 1'b0};
            16: r = '{6'h03, 6'h2A, KJump,  4'd0, 1'b0, 1'b0};
            17: r = '{6'h23, 6'h00, KLoad,  4'd2, 1'b1, 1'b1};
            18: r = '{6'h24, 6'h08, KLoad,  4'd2, 1'b1, 1'b0};
            19: r = '{6'h2B, 6'h00, KStore, 4'd2, 1'b1, 1'b1};
            default: r = '{6'h28, 6'h20, KStore, 4'd2, 1'b1, 1'b0};
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic rdy, input logic z);
        bus.mem_ready = rdy;
        bus.zero      = z;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        put(1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.opcode = 6'h23;
        bus.funct  = 6'h20;
        put(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            assertions++;
            if (any_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs_zero: got %b want 0", any_out);
            end
            tick();
        end
        rst = 1'b1;
        put(1'b0, 1'b0);
        assertions++;
        if ({bus.state, bus.mem_req, bus.MemRead, bus.ALUSrc, bus.ALUOp, bus.IRWrite, bus.trap,
             bus.instr_count} !== {3'd0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL reset_fetch: st=%0d req=%b rd=%b src=%b alu=%0d ir=%b trap=%b cnt=%0d",
                     bus.state, bus.mem_req, bus.MemRead, bus.ALUSrc, bus.ALUOp, bus.IRWrite,
                     bus.trap, bus.instr_count);
        end
    endtask

    task automatic test_add();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        do_reset();
        bus.opcode = 6'h00;
        bus.funct  = 6'h20;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 1'b0);
            assertions++;
            if (bus.state !== exp_st[i]) begin
                failures++;
                $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]);
            end
            if (i == 3) begin
                assertions++;
                if ({bus.RegWrite, bus.RegDst, bus.MemToReg} !== 3'b110) begin
                    failures++;
                    $display("FAIL add_wb: RegWrite/RegDst/MemToReg got %b want 110",
                             {bus.RegWrite, bus.RegDst, bus.MemToReg});
                end
            end
            tick();
        end
        assertions++;
        if (bus.state !== 3'd0 || bus.instr_count !== 4'd1) begin
            failures++;
            $display("FAIL add_retire: state %0d count %0d want 0 1", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_lw_delay();
        int reqs = 0;
        do_reset();
        bus.opcode = 6'h23;
        bus.funct  = 6'h00;
        put(1'b1, 1'b0);
        tick();
        tick();
        put(1'b0, 1'b0);
        assertions++;
        if ({bus.state, bus.ALUSrc, bus.ZorS, bus.ALUOp, bus.BW} !== {3'd2, 1'b1, 1'b1, 4'd2, 1'b1})
        begin
            failures++;
            $display("FAIL lw_exec: st=%0d src=%b zs=%b alu=%0d bw=%b", bus.state, bus.ALUSrc,
                     bus.ZorS, bus.ALUOp, bus.BW);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            put(i == 3, 1'b0);
            if (bus.state == 3'd3 && bus.mem_req && bus.IorD && bus.MemRead) reqs++;
            tick();
        end
        assertions++;
        if (reqs !== 4) begin
            failures++;
            $display("FAIL lw_req_hold: got %0d cycles want 4", reqs);
        end
        assertions++;
        if ({bus.state, bus.RegWrite, bus.MemToReg, bus.BW} !== {3'd4, 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL lw_wb: st=%0d rw=%b m2r=%b bw=%b", bus.state, bus.RegWrite,
                     bus.MemToReg, bus.BW);
        end
        tick();
        assertions++;
        if (bus.state !== 3'd0 || bus.instr_count !== 4'd1) begin
            failures++;
            $display("FAIL lw_retire: state %0d count %0d want 0 1", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_beq();
        logic zv;
        do_reset();
        bus.opcode = 6'h04;
        bus.funct  = 6'h00;
        for (int k = 0; k < 2; k++) begin
            zv = (k == 0);
            put(1'b1, zv);
            tick();
            tick();
            put(1'b1, zv);
            assertions++;
            if ({bus.state, bus.PCWrite, bus.Branch, bus.BNE, bus.ALUOp} !==
                {3'd2, zv, 1'b1, 1'b0, 4'd6}) begin
                failures++;
                $display("FAIL beq_exec_z%0b: st=%0d pcw=%b br=%b bne=%b alu=%0d want pcw=%b",
                         zv, bus.state, bus.PCWrite, bus.Branch, bus.BNE, bus.ALUOp, zv);
            end
            tick();
            assertions++;
            if (bus.state !== 3'd0 || bus.instr_count !== 4'(k + 1)) begin
                failures++;
                $display("FAIL beq_retire_z%0b: state %0d count %0d want 0 %0d", zv, bus.state,
                         bus.instr_count, k + 1);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2] = '{6'h3F, 6'h00};
        logic [5:0] fns [2] = '{6'h20, 6'h21};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.opcode = ops[k];
            bus.funct  = fns[k];
            put(1'b1, 1'b0);
            tick();
            tick();
            for (int i = 0; i < 3; i++) begin
                put(1'b1, 1'b1);
                assertions++;
                if ({bus.state, bus.trap, bus.trap_cause, bus.instr_count, bus.mem_req,
                     bus.PCWrite} !== {3'd5, 1'b1, 2'b01, 4'd0, 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL illegal_trap[%0d]: st=%0d trap=%b cause=%b cnt=%0d req=%b",
                             k, bus.state, bus.trap, bus.trap_cause, bus.instr_count,
                             bus.mem_req);
                end
                tick();
            end
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        put(1'b0, 1'b0);
        assertions++;
        if ({bus.state, bus.trap, bus.trap_cause} !== {3'd0, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL illegal_release: st=%0d trap=%b cause=%b", bus.state, bus.trap,
                     bus.trap_cause);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.opcode = 6'h00;
        bus.funct  = 6'h20;
        for (int i = 0; i < 5; i++) begin
            put(1'b0, 1'b0);
            assertions++;
            if (bus.state !== 3'd0 || bus.IRWrite !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait[%0d]: st=%0d ir=%b want 0 0", i, bus.state,
                         bus.IRWrite);
            end
            tick();
        end
        assertions++;
        if ({bus.state, bus.trap, bus.trap_cause} !== {3'd5, 1'b1, 2'b10}) begin
            failures++;
            $display("FAIL timeout_fetch_trap: st=%0d trap=%b cause=%b", bus.state, bus.trap,
                     bus.trap_cause);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(1'b0, 1'b0);
            tick();
        end
        put(1'b1, 1'b0);
        assertions++;
        if (bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1) begin
            failures++;
            $display("FAIL timeout_late_ready: IRWrite/PCWrite got %b%b want 11", bus.IRWrite,
                     bus.PCWrite);
        end
        tick();
        assertions++;
        if (bus.state !== 3'd1 || bus.trap !== 1'b0) begin
            failures++;
            $display("FAIL timeout_late_ready_next: st=%0d trap=%b want 1 0", bus.state, bus.trap);
        end
        do_reset();
        bus.opcode = 6'h2B;
        put(1'b1, 1'b0);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            put(1'b0, 1'b0);
            tick();
        end
        assertions++;
        if ({bus.state, bus.trap_cause, bus.instr_count} !== {3'd5, 2'b10, 4'd0}) begin
            failures++;
            $display("FAIL timeout_mem_trap: st=%0d cause=%b cnt=%0d", bus.state, bus.trap_cause,
                     bus.instr_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.opcode = 6'h02;
        bus.funct  = 6'h00;
        for (int n = 0; n < 17; n++) begin
            put(1'b1, 1'b0);
            tick();
            tick();
            tick();
            if (n >= 14) begin
                assertions++;
                if (bus.instr_count !== 4'((n + 1) % 16)) begin
                    failures++;
                    $display("FAIL wrap_count[%0d]: got %0d want %0d", n, bus.instr_count,
                             (n + 1) % 16);
                end
            end
        end
        bus.opcode = 6'h23;
        tick();
        tick();
        tick();
        put(1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        assertions++;
        if (any_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_mem_reset_outputs: got %b want 0", any_out);
        end
        tick();
        rst = 1'b1;
        #1;
        assertions++;
        if ({bus.state, bus.instr_count, bus.mem_req, bus.IorD} !== {3'd0, 4'd0, 1'b1, 1'b0})
        begin
            failures++;
            $display("FAIL mid_mem_release: st=%0d cnt=%0d req=%b iord=%b", bus.state,
                     bus.instr_count, bus.mem_req, bus.IorD);
        end
    endtask

    task automatic test_random();
        ins_t       ins;
        int         phases[$];
        int         n, fw, mw, cnt;
        logic       zv, rdy, exp_pcw, exp_rd;
        cnt = 0;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            ins = ins_info($urandom_range(0, 20));
            fw  = $urandom_range(0, 4);
            mw  = $urandom_range(0, 4);
            zv  = 1'($urandom_range(0, 1));
            bus.opcode = ins.op;
            bus.funct  = ins.fn;
            case (ins.kind)
                KAlu:    phases = '{0, 1, 2, 4};
                KLoad:   phases = '{0, 1, 2, 3, 4};
                KStore:  phases = '{0, 1, 2, 3};
                default: phases = '{0, 1, 2};
            endcase
            exp_pcw = (ins.kind == KJump) ||
                      (ins.kind == KBr && ((ins.op == 6'h04) ? zv : !zv));
            exp_rd  = (ins.kind == KAlu) && (ins.op == 6'h00);
            foreach (phases[p]) begin
                n = (phases[p] == 0) ? fw + 1 : (phases[p] == 3) ? mw + 1 : 1;
                for (int c = 0; c < n; c++) begin
                    if (phases[p] == 0 || phases[p] == 3) rdy = (c == n - 1);
                    else rdy = 1'($urandom_range(0, 1));
                    put(rdy, zv);
                    assertions++;
                    if (bus.state !== 3'(phases[p]) ||
                        bus.mem_req !== (phases[p] == 0 || phases[p] == 3)) begin
                        failures++;
                        $display("FAIL rand_state[%0d] op=%h fn=%h: st=%0d req=%b want st=%0d",
                                 k, ins.op, ins.fn, bus.state, bus.mem_req, phases[p]);
                    end
                    if (phases[p] == 2) begin
                        assertions++;
                        if ({bus.ALUOp, bus.PCWrite, bus.ZorS, bus.BW, bus.RegDst} !==
                            {ins.alu, exp_pcw, ins.zors, ins.bw, exp_rd}) begin
                            failures++;
                            $display("FAIL rand_exec[%0d] op=%h fn=%h z=%b: got %b want %b", k,
                                     ins.op, ins.fn, zv,
                                     {bus.ALUOp, bus.PCWrite, bus.ZorS, bus.BW, bus.RegDst},
                                     {ins.alu, exp_pcw, ins.zors, ins.bw, exp_rd});
                        end
                    end
                    if (phases[p] == 3) begin
                        assertions++;
                        if ({bus.MemWrite, bus.MemRead, bus.IorD} !==
                            {ins.kind == KStore, ins.kind == KLoad, 1'b1}) begin
                            failures++;
                            $display("FAIL rand_mem[%0d] op=%h: wr/rd/iord got %b%b%b", k, ins.op,
                                     bus.MemWrite, bus.MemRead, bus.IorD);
                        end
                    end
                    if (phases[p] == 4) begin
                        assertions++;
                        if ({bus.RegWrite, bus.MemToReg, bus.RegDst} !==
                            {1'b1, ins.kind == KLoad, exp_rd}) begin
                            failures++;
                            $display("FAIL rand_wb[%0d] op=%h: rw/m2r/rd got %b%b%b", k, ins.op,
                                     bus.RegWrite, bus.MemToReg, bus.RegDst);
                        end
                    end
                    tick();
                end
            end
            cnt = (cnt + 1) % 16;
            assertions++;
            if (bus.state !== 3'd0 || bus.instr_count !== 4'(cnt)) begin
                failures++;
                $display("FAIL rand_retire[%0d] op=%h: st=%0d cnt=%0d want 0 %0d", k, ins.op,
                         bus.state, bus.instr_count, cnt);
            end
        end
    endtask

    initial begin
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_delay();
        test_beq();
        test_illegal();
        test_timeout();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
